// File: rtl/truth_table_lut.sv
// Run-time programmable N_IN-input truth table with serial atomic load and
// an exhaustive row sweep. Row r selects table_q[W-1-r] (MSB is row 0).
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | evaluate in_valid requests, accept cfg_start / sweep_start
//   S_LOAD  | shift serial bits into shadow, commit on the W-th bit
//   S_SWEEP | present one table row per cycle, idx 0..W-1
module truth_table_lut #(
  parameter int          N_IN        = 3,
  parameter logic [63:0] RESET_TABLE = 64'hA1,
  localparam int         W           = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in,
  input  logic            in_valid,
  output logic            out,
  output logic            out_valid,
  input  logic            cfg_start,
  input  logic            cfg_bit,
  input  logic            cfg_bit_valid,
  output logic            cfg_done,
  input  logic            sweep_start,
  output logic            sweep_valid,
  output logic [N_IN-1:0] sweep_idx,
  output logic            sweep_out,
  output logic            sweep_last,
  output logic            busy,
  output logic [W-1:0]    table_q
);

  localparam logic [W-1:0] RESET_W = RESET_TABLE[W-1:0];

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP} state_t;

  state_t          state;
  logic [W-1:0]    shadow;
  logic [N_IN-1:0] bit_cnt;
  logic [W-1:0]    shadow_next;
  logic [N_IN-1:0] idx_next;

  assign shadow_next = {shadow[W-2:0], cfg_bit};
  assign idx_next    = sweep_idx + N_IN'(1);

  // W-1-r equals the bitwise complement of r, so ~row is the table bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      table_q     <= RESET_W;
      shadow      <= '0;
      bit_cnt     <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      cfg_done    <= 1'b0;
      sweep_valid <= 1'b0;
      sweep_idx   <= '0;
      sweep_out   <= 1'b0;
      sweep_last  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      cfg_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            out       <= table_q[~in];
            out_valid <= 1'b1;
          end
          if (cfg_start) begin
            state   <= S_LOAD;
            busy    <= 1'b1;
            bit_cnt <= '0;
            shadow  <= '0;
          end else if (sweep_start) begin
            state       <= S_SWEEP;
            busy        <= 1'b1;
            sweep_valid <= 1'b1;
            sweep_idx   <= '0;
            sweep_out   <= table_q[W-1];
            sweep_last  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (cfg_start) begin
            bit_cnt <= '0;
            shadow  <= '0;
          end else if (cfg_bit_valid) begin
            shadow  <= shadow_next;
            bit_cnt <= bit_cnt + N_IN'(1);
            if (&bit_cnt) begin
              table_q  <= shadow_next;
              cfg_done <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        S_SWEEP: begin
          if (sweep_last) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_last  <= 1'b0;
            sweep_idx   <= '0;
            sweep_out   <= 1'b0;
          end else begin
            sweep_idx  <= idx_next;
            sweep_out  <= table_q[~idx_next];
            sweep_last <= &idx_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_lut.sv
// Directed + randomized bench for truth_table_lut (N_IN=3 default instance
// and an N_IN=4 instance), checked against a shift-based table model.
module tb_truth_table_lut;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in = '0;
  logic       in_valid = 1'b0, cfg_start = 1'b0, cfg_bit = 1'b0, cfg_bit_valid = 1'b0, sweep_start = 1'b0;
  logic       out, out_valid, cfg_done, sweep_valid, sweep_out, sweep_last, busy;
  logic [2:0] sweep_idx;
  logic [7:0] table_q;

  logic [3:0] in4 = '0;
  logic       in_valid4 = 1'b0, sweep_start4 = 1'b0;
  logic       cfg_start4 = 1'b0, cfg_bit4 = 1'b0, cfg_bit_valid4 = 1'b0;
  logic       out4, out_valid4, cfg_done4, sweep_valid4, sweep_out4, sweep_last4, busy4;
  logic [3:0] sweep_idx4;
  logic [15:0] table_q4;

  int checks = 0;
  int failures = 0;
  logic [7:0]  ref3 = 8'hA1;
  logic [15:0] ref4 = 16'h8001;

  always #5 clk = ~clk;

  truth_table_lut dut3 (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .out(out), .out_valid(out_valid),
    .cfg_start(cfg_start), .cfg_bit(cfg_bit), .cfg_bit_valid(cfg_bit_valid), .cfg_done(cfg_done),
    .sweep_start(sweep_start), .sweep_valid(sweep_valid), .sweep_idx(sweep_idx),
    .sweep_out(sweep_out), .sweep_last(sweep_last), .busy(busy), .table_q(table_q)
  );

  truth_table_lut #(.N_IN(4), .RESET_TABLE(64'h8001)) dut4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .in_valid(in_valid4), .out(out4), .out_valid(out_valid4),
    .cfg_start(cfg_start4), .cfg_bit(cfg_bit4), .cfg_bit_valid(cfg_bit_valid4), .cfg_done(cfg_done4),
    .sweep_start(sweep_start4), .sweep_valid(sweep_valid4), .sweep_idx(sweep_idx4),
    .sweep_out(sweep_out4), .sweep_last(sweep_last4), .busy(busy4), .table_q(table_q4)
  );

  // Row r of a W-bit table: shift the table right so row r lands in bit 0.
  function automatic logic row_bit(input logic [63:0] t, input int w, input int r);
    logic [63:0] s;
    s = (t >> (w - 1 - r)) & 64'd1;
    return s[0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic eval_rows(input int n, input bit seq);
    int r;
    r = 0;
    for (int i = 0; i < n; i++) begin
      r = seq ? i : int'($urandom_range(0, 7));
      in = 3'(r);
      in_valid = 1'b1;
      @(negedge clk);
      chk("eval_out", out, row_bit(ref3, 8, r));
      chk("eval_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("eval_pulse_end", out_valid, 0);
    chk("eval_hold", out, row_bit(ref3, 8, r));
  endtask

  task automatic load3(input logic [7:0] val, input int abort_after, input bit with_sweep);
    int gap;
    cfg_start = 1'b1;
    sweep_start = with_sweep;
    @(negedge clk);
    cfg_start = 1'b0;
    sweep_start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_no_sweep_start", sweep_valid, 0);
    if (abort_after > 0) begin
      for (int i = 0; i < abort_after; i++) begin
        cfg_bit = 1'($urandom);
        cfg_bit_valid = 1'b1;
        @(negedge clk);
      end
      cfg_start = 1'b1;
      cfg_bit = 1'b1;
      cfg_bit_valid = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_bit_valid = 1'b0;
      chk("abort_busy", busy, 1);
      chk("abort_table", table_q, ref3);
    end
    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cfg_bit_valid = 1'b0;
        in = 3'($urandom);
        in_valid = 1'b1;
        sweep_start = 1'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        sweep_start = 1'b0;
        chk("load_no_eval", out_valid, 0);
        chk("load_no_sweep", sweep_valid, 0);
      end
      cfg_bit = val[7-i];
      cfg_bit_valid = 1'b1;
      @(negedge clk);
      cfg_bit_valid = 1'b0;
      if (i < 7) begin
        chk("load_partial", table_q, ref3);
        chk("load_no_done", cfg_done, 0);
        chk("load_still_busy", busy, 1);
      end
    end
    ref3 = val;
    chk("load_table", table_q, ref3);
    chk("load_done", cfg_done, 1);
    chk("load_idle", busy, 0);
    @(negedge clk);
    chk("load_done_pulse", cfg_done, 0);
  endtask

  task automatic sweep3(input bit hold);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = hold;
    for (int k = 0; k < 8; k++) begin
      chk("sweep_valid", sweep_valid, 1);
      chk("sweep_idx", sweep_idx, 64'(k));
      chk("sweep_out", sweep_out, row_bit(ref3, 8, k));
      chk("sweep_last", sweep_last, (k == 7) ? 1 : 0);
      chk("sweep_busy", busy, 1);
      if (k == 7) sweep_start = 1'b0;
      @(negedge clk);
    end
    chk("sweep_end_valid", sweep_valid, 0);
    chk("sweep_end_busy", busy, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_table", table_q, 8'hA1);
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_sweep_valid", sweep_valid, 0);
    chk("rst_sweep_last", sweep_last, 0);
    chk("rst_sweep_idx", sweep_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_table4", table_q4, 16'h8001);
    rst_n = 1'b1;
    @(negedge clk);

    eval_rows(8, 1'b1);
    load3(8'h96, 0, 1'b0);
    sweep3(1'b0);
    load3(8'hFF, 3, 1'b0);
    eval_rows(8, 1'b1);

    // Reset in the middle of loading 0x00.
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_bit = 1'b0;
      cfg_bit_valid = 1'b1;
      @(negedge clk);
    end
    cfg_bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    ref3 = 8'hA1;
    chk("midload_rst_table", table_q, ref3);
    chk("midload_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep3(1'b0);

    load3(8'($urandom), 0, 1'b1);
    sweep3(1'b1);

    for (int n = 0; n < 8; n++) begin
      load3(8'($urandom), int'($urandom_range(0, 4)), 1'b0);
      eval_rows(6, 1'b0);
      sweep3(1'($urandom));
    end

    for (int r = 0; r < 16; r++) begin
      in4 = 4'(r);
      in_valid4 = 1'b1;
      @(negedge clk);
      chk("eval4_out", out4, row_bit(ref4, 16, r));
      chk("eval4_valid", out_valid4, 1);
    end
    in_valid4 = 1'b0;
    sweep_start4 = 1'b1;
    @(negedge clk);
    sweep_start4 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("sweep4_valid", sweep_valid4, 1);
      chk("sweep4_idx", sweep_idx4, 64'(k));
      chk("sweep4_out", sweep_out4, row_bit(ref4, 16, k));
      chk("sweep4_last", sweep_last4, (k == 15) ? 1 : 0);
      @(negedge clk);
    end
    chk("sweep4_end", sweep_valid4, 0);
    chk("sweep4_busy_end", busy4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
